banked_mem_responder: RTL and testbench

- Synthesizable four-bank interleaved word memory that answers the cache controller's memory-side requests: `addr`, `data_in`, `rd`, `wr` in; `data_out`, `stall`, `busy`, `err` out.
- Serves as the drop-in backing store behind the two-way cache in RTL simulation and FPGA builds.
- Banks are selected by word address; each bank is occupied for several cycles per access.
- Read data returns with fixed latency, so a controller can pipeline one access per cycle across the four banks.

---
 rtl/banked_mem_responder.sv | 113 +++++++++++
 tb/tb_banked_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-bank interleaved 16-bit word memory.
// Bank = addr[2:1]. An accepted access keeps its bank busy for BANK_BUSY cycles.
// Reads return on data_out exactly two cycles after acceptance.
// data_out is zero in every other cycle.
`timescale 1ns/1ps
module banked_mem_responder #(
  parameter int MEM_WORDS_LOG2 = 15,
  parameter int BANK_BUSY      = 4    // legal range 2..7 (fits the 3-bit counters)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int         DEPTH     = 1 << MEM_WORDS_LOG2;
  localparam logic [2:0] BUSY_LOAD = 3'(BANK_BUSY - 1);

  // Storage has no reset, so it can map onto block RAM.
  // Contents therefore survive rst_n.
  logic [15:0] mem_q [DEPTH];
  logic [15:0] rd_data_q;

  // Return pipe and error flag (async reset).
  logic        rd_vld_q;
  logic [15:0] data_out_q;
  logic        err_q;

  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic [1:0]                bank_sel;
  logic                      req;
  logic                      illegal;
  logic                      legal_req;
  logic                      accept;
  logic                      wr_accept;
  logic                      rd_accept;

  // Upper address bits beyond the word index are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign word_idx  = addr[MEM_WORDS_LOG2:1];
  assign bank_sel  = addr[2:1];
  assign req       = rd | wr;
  assign illegal   = (rd & wr) | addr[0];
  assign legal_req = req & ~illegal;
  assign stall     = legal_req & busy[bank_sel];
  assign accept    = legal_req & ~stall;
  assign wr_accept = accept & wr;
  assign rd_accept = accept & rd;

  // One occupancy counter per bank.
  // It reloads on acceptance and otherwise counts down to zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Next count: reload on acceptance into this bank, else saturating decrement.
    always_comb begin
      cnt_d = cnt_q;
      if (accept && (bank_sel == 2'(gi))) begin
        cnt_d = BUSY_LOAD;
      end else if (cnt_q != 3'd0) begin
        cnt_d = cnt_q - 3'd1;
      end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= 3'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy[gi] = (cnt_q != 3'd0);
  end

  // Memory write and registered read.
  // The read word is the first stage of the return pipe.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[word_idx] <= data_in;
    end
    if (rd_accept) begin
      rd_data_q <= mem_q[word_idx];
    end
  end

  // Return-pipe valid, gated output word and one-cycle error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      data_out_q <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      rd_vld_q   <= rd_accept;
      data_out_q <= rd_vld_q ? rd_data_q : 16'h0000;
      err_q      <= req & illegal;
    end
  end

  assign data_out = data_out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed testbench for banked_mem_responder.
// Inputs are driven 1ns after the rising edge; outputs are checked 3ns after it.
`timescale 1ns/1ps
module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, data_in, data_out;
  logic        rd, wr, stall, err;
  logic [3:0]  busy;

  logic [15:0] w_addr, w_data_in, w_data_out;
  logic        w_rd, w_wr, w_stall, w_err;
  logic [3:0]  w_busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  banked_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .stall(stall), .busy(busy), .err(err)
  );

  banked_mem_responder #(.MEM_WORDS_LOG2(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .addr(w_addr), .data_in(w_data_in), .rd(w_rd), .wr(w_wr),
    .data_out(w_data_out), .stall(w_stall), .busy(w_busy), .err(w_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total = total + 1;
    assert (obs === exp_v) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle on the main instance: drive, then settle to the check point.
  task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; data_in = d;
    #2;
  endtask

  // One clock cycle on the narrow-memory instance.
  task automatic cycw(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    w_rd = r; w_wr = w; w_addr = a; w_data_in = d;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin : stim
    logic [15:0] fill_addr [4];
    logic [15:0] fill_dout [8];
    logic [3:0]  fill_busy [8];
    fill_addr = '{16'h0A38, 16'h0A3A, 16'h0A3C, 16'h0A3E};
    fill_dout = '{16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000, 16'h0000};
    fill_busy = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};

    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    w_rd = 1'b0; w_wr = 1'b0; w_addr = '0; w_data_in = '0;

    // Reset values.
    idle(2);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_err", 16'(err), 16'h0000);
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_stall", 16'(stall), 16'h0000);
    rst_n = 1'b1;

    // Write then read: write in cycle 0, read in cycle 4.
    cyc(1'b0, 1'b1, 16'h0100, 16'hBEEF);
    chk("wr_stall", 16'(stall), 16'h0000);
    idle(1);
    chk("wr_busy_c1", 16'(busy), 16'h0001);
    idle(2);
    chk("wr_busy_c3", 16'(busy), 16'h0001);
    cyc(1'b1, 1'b0, 16'h0100, 16'h0000);
    chk("rd_stall_c4", 16'(stall), 16'h0000);
    chk("rd_busy_c4", 16'(busy), 16'h0000);
    idle(1);
    chk("rd_dout_c5", data_out, 16'h0000);
    idle(1);
    chk("rd_dout_c6", data_out, 16'hBEEF);
    idle(1);
    chk("rd_dout_c7", data_out, 16'h0000);

    // Line fill: preload four banks, then back-to-back reads.
    cyc(1'b0, 1'b1, 16'h0A38, 16'h1111);
    cyc(1'b0, 1'b1, 16'h0A3A, 16'h2222);
    cyc(1'b0, 1'b1, 16'h0A3C, 16'h3333);
    cyc(1'b0, 1'b1, 16'h0A3E, 16'h4444);
    chk("pre_stall", 16'(stall), 16'h0000);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) cyc(1'b1, 1'b0, fill_addr[i], 16'h0000);
      else       cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
      $display("fill cycle %0d: stall=%0b busy=%b dout=%h", i, stall, busy, data_out);
      chk($sformatf("fill_stall_c%0d", i), 16'(stall), 16'h0000);
      chk($sformatf("fill_busy_c%0d", i), 16'(busy), 16'(fill_busy[i]));
      chk($sformatf("fill_dout_c%0d", i), data_out, fill_dout[i]);
    end

    // Bank conflict: 0x0000 and 0x0008 both map to bank 0.
    cyc(1'b0, 1'b1, 16'h0000, 16'hC0DE);
    idle(3);
    cyc(1'b0, 1'b1, 16'h0008, 16'h0808);
    idle(3);
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("cf_stall_c0", 16'(stall), 16'h0000);
    for (int k = 1; k < 4; k++) begin
      cyc(1'b1, 1'b0, 16'h0008, 16'h0000);
      chk($sformatf("cf_stall_c%0d", k), 16'(stall), 16'h0001);
      chk($sformatf("cf_dout_c%0d", k), data_out, (k == 2) ? 16'hC0DE : 16'h0000);
    end
    cyc(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("cf_stall_c4", 16'(stall), 16'h0000);
    idle(1);
    chk("cf_dout_c5", data_out, 16'h0000);
    idle(1);
    chk("cf_dout_c6", data_out, 16'h0808);
    idle(1);

    // Illegal requests: rd&wr, then a write to an odd byte address.
    cyc(1'b0, 1'b1, 16'h0010, 16'h1234);
    idle(3);
    cyc(1'b1, 1'b1, 16'h0010, 16'hFFFF);
    chk("il_stall_c0", 16'(stall), 16'h0000);
    chk("il_err_c0", 16'(err), 16'h0000);
    idle(1);
    chk("il_err_c1", 16'(err), 16'h0001);
    chk("il_busy_c1", 16'(busy), 16'h0000);
    cyc(1'b0, 1'b1, 16'h0011, 16'hFFFF);
    chk("il_stall_c2", 16'(stall), 16'h0000);
    chk("il_err_c2", 16'(err), 16'h0000);
    idle(1);
    chk("il_err_c3", 16'(err), 16'h0001);
    chk("il_busy_c3", 16'(busy), 16'h0000);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("il_err_c4", 16'(err), 16'h0000);
    chk("il_stall_c4", 16'(stall), 16'h0000);
    idle(2);
    chk("il_word", data_out, 16'h1234);
    idle(1);

    // Reset with two reads in flight.
    cyc(1'b1, 1'b0, 16'h0100, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0A3A, 16'h0000);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 16'(busy), 16'h0000);
    chk("mr_err", 16'(err), 16'h0000);
    chk("mr_dout", data_out, 16'h0000);
    idle(1);
    chk("mr_dout_held", data_out, 16'h0000);
    rst_n = 1'b1;
    idle(1);
    chk("mr_dout_p1", data_out, 16'h0000);
    idle(1);
    chk("mr_dout_p2", data_out, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0A3A, 16'h0000);
    chk("mr_stall", 16'(stall), 16'h0000);
    idle(2);
    chk("mr_reread", data_out, 16'h2222);

    // Address wrap on the 16-word instance.
    cycw(1'b0, 1'b1, 16'h0002, 16'h5A5A);
    for (int i = 0; i < 3; i++) cycw(1'b0, 1'b0, 16'h0000, 16'h0000);
    cycw(1'b1, 1'b0, 16'h0022, 16'h0000);
    chk("wrap_stall", 16'(w_stall), 16'h0000);
    cycw(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wrap_dout_c5", w_data_out, 16'h0000);
    cycw(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wrap_dout_c6", w_data_out, 16'h5A5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
